// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared FSM state encoding, access-size codes and lane helpers
//                for the data-memory bus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam logic [2:0]  SZ_BYTE          = 3'b001;
    localparam logic [2:0]  SZ_HALF          = 3'b011;
    localparam logic [2:0]  SZ_WORD          = 3'b111;
    localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

    // The size code doubles as a right-aligned byte-lane mask.
    function automatic logic [3:0] size_lanes(input logic [2:0] size);
        return {size[2], size[2], size[1], size[0]};
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_ctrl_if
//  Description : CPU data-port bus between the processor (master) and the
//                data-memory controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bus_ctrl_if;

    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        memread_i;
    logic        memwrite_i;
    logic [3:0]  sign_mask_i;
    logic [31:0] rdata_o;
    logic        stall_o;

    modport master (
        output addr_i, wdata_i, memread_i, memwrite_i, sign_mask_i,
        input  rdata_o, stall_o
    );

    modport slave (
        input  addr_i, wdata_i, memread_i, memwrite_i, sign_mask_i,
        output rdata_o, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational load lane extract/extend and store lane merge,
//                keyed by size, byte offset and sign. Lanes past byte 3 drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [2:0]  size_i,
    input  wire logic [1:0]  off_i,
    input  wire logic        sign_i,
    input  wire logic [31:0] ram_word_i,
    input  wire logic [31:0] wdata_i,
    output logic      [31:0] load_o,
    output logic      [31:0] merged_o
);

    logic [3:0]  w_lanes;
    logic [31:0] w_bits;
    logic [4:0]  w_shift;
    logic [31:0] w_field;
    logic        w_sbit;
    logic [31:0] w_st_bits;

    assign w_lanes = size_lanes(size_i);
    assign w_bits  = lane_bits(w_lanes);
    assign w_shift = {off_i, 3'b000};
    assign w_field = (ram_word_i >> w_shift) & w_bits;

    always_comb begin
        if (w_lanes[3])
            w_sbit = w_field[31];
        else if (w_lanes[1])
            w_sbit = w_field[15];
        else
            w_sbit = w_field[7];
    end

    assign load_o    = (sign_i && w_sbit) ? (w_field | ~w_bits) : w_field;
    assign w_st_bits = w_bits << w_shift;
    assign merged_o  = (ram_word_i & ~w_st_bits) | ((wdata_i << w_shift) & w_st_bits);

endmodule
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_ctrl
//  Description : Data-memory controller: sync-read RAM with stall handshake,
//                sub-word loads/stores (RMW) and an LED register.
//                Optional macro DMEM_MISALIGN_ERR_EN adds sticky err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter int          LED_W       = 8,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    dmem_bus_ctrl_if.slave                      bus,
    output logic      [LED_W-1:0]               led_o,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic                                err_o,
`endif
    output logic      [$clog2(DEPTH_WORDS)-1:0] ram_addr_o,
    output logic      [31:0]                    ram_wdata_o,
    output logic                                ram_we_o,
    input  wire logic [31:0]                    ram_rdata_i
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [1:0]  c_WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    dmem_state_t    r_state;
    logic [1:0]     r_cnt;
    logic           r_is_wr;
    logic [AW-1:0]  r_word_addr;
    logic [2:0]     r_size;
    logic [1:0]     r_off;
    logic           r_sign;
    logic [LED_W-1:0] r_led;

    logic        w_ram_hit;
    logic        w_led_hit;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_size;
    logic [1:0]  w_off;
    logic        w_full_word;
    logic        w_misalign;
    logic        w_err_req;
    logic        w_word_store;
    logic        w_stall_req;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_stall;
    logic        w_we;
    logic [31:0] w_rdata;
    logic [AW-1:0] w_ram_addr;
    logic [31:0] w_ram_wdata;

    assign w_ram_hit   = bus.addr_i < c_RAM_BYTES;
    assign w_led_hit   = bus.addr_i[31:2] == LED_ADDR[31:2];
    assign w_wr        = bus.memwrite_i;
    assign w_rd        = bus.memread_i & ~bus.memwrite_i;
    assign w_size      = bus.sign_mask_i[2:0];
    assign w_off       = bus.addr_i[1:0];
    assign w_full_word = (w_size == SZ_WORD) && (w_off == 2'b00);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = ((w_size == SZ_HALF) && w_off[0]) ||
                        ((w_size == SZ_WORD) && (w_off != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err_req    = (w_wr | w_rd) & w_misalign;
    assign w_word_store = w_wr & w_ram_hit & w_full_word & ~w_err_req;
    // Anything touching RAM except an aligned full-word store needs read data.
    assign w_stall_req  = w_ram_hit & ~w_err_req & (w_rd | (w_wr & ~w_full_word));

    dmem_lane_align u_lane_align (
        .size_i     (r_size),
        .off_i      (r_off),
        .sign_i     (r_sign),
        .ram_word_i (ram_rdata_i),
        .wdata_i    (bus.wdata_i),
        .load_o     (w_load),
        .merged_o   (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_is_wr     <= 1'b0;
            r_word_addr <= '0;
            r_size      <= 3'd0;
            r_off       <= 2'd0;
            r_sign      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stall_req) begin
                        r_is_wr     <= w_wr;
                        r_word_addr <= bus.addr_i[AW+1:2];
                        r_size      <= w_size;
                        r_off       <= w_off;
                        r_sign      <= bus.sign_mask_i[3];
                        r_cnt       <= 2'd0;
                        r_state     <= (RD_LAT == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == c_WAIT_LAST)
                        r_state <= ST_DONE;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_led <= '0;
        else if ((r_state == ST_IDLE) && w_wr && w_led_hit && !w_err_req)
            r_led <= bus.wdata_i[LED_W-1:0];
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((r_state == ST_IDLE) && w_err_req)
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`endif

    always_comb begin
        w_stall     = 1'b0;
        w_we        = 1'b0;
        w_rdata     = 32'd0;
        w_ram_addr  = bus.addr_i[AW+1:2];
        w_ram_wdata = bus.wdata_i;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_stall_req;
                w_we    = w_word_store;
                if (w_rd && w_led_hit && !w_err_req)
                    w_rdata = 32'(r_led);
            end
            ST_WAIT: begin
                w_stall    = 1'b1;
                w_ram_addr = r_word_addr;
            end
            ST_DONE: begin
                w_ram_addr = r_word_addr;
                if (r_is_wr) begin
                    w_we        = 1'b1;
                    w_ram_wdata = w_merged;
                end else begin
                    w_rdata = w_load;
                end
            end
            default: ;
        endcase
    end

    // Reset forces the handshake outputs low immediately, even mid-request.
    assign bus.stall_o  = w_stall & ~rst;
    assign bus.rdata_o  = rst ? 32'd0 : w_rdata;
    assign ram_we_o     = w_we & ~rst;
    assign ram_addr_o   = w_ram_addr;
    assign ram_wdata_o  = w_ram_wdata;
    assign led_o        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bus_ctrl
//  Description : Scoreboard bench for dmem_bus_ctrl with a byte-level
//                reference model and a latency-RD_LAT block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1024;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          stalls;
        int          wes;
        logic [7:0]  led;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic [7:0]  led;
    logic        err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] tb_ram [DEPTH];
    logic [31:0] pipe1;

    logic [31:0] ref_mem [DEPTH];
    logic [7:0]  ref_led = 8'd0;
    logic        ref_err = 1'b0;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    dmem_bus_ctrl_if bus ();

    dmem_bus_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .RD_LAT      (RD_LAT),
        .LED_W       (8),
        .LED_ADDR    (32'h2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .led_o       (led),
`ifdef DMEM_MISALIGN_ERR_EN
        .err_o       (err),
`endif
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata)
    );

`ifndef DMEM_MISALIGN_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) tb_ram[i] <= 32'd0;
        end else if (ram_we) begin
            tb_ram[ram_addr] <= ram_wdata;
        end
        pipe1     <= tb_ram[ram_addr];
        ram_rdata <= pipe1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-wise memory semantics, updates ref state.
    task automatic model(input logic [31:0] a, input logic [31:0] w, input logic rd,
                         input logic wr, input logic [3:0] sm, output exp_t e);
        int nb, off, idx;
        logic is_ram, is_led, load, store, mis;
        logic [63:0] v;
        nb     = (sm[2:0] == 3'b001) ? 1 : (sm[2:0] == 3'b011) ? 2 : 4;
        off    = int'(a % 4);
        idx    = int'(a / 4);
        is_ram = a < 32'(4 * DEPTH);
        is_led = (a / 4) == (32'h2000 / 4);
        store  = wr;
        load   = rd && !wr;
        e.is_load = load;
        e.rdata   = 32'd0;
        e.stalls  = 0;
        e.wes     = 0;
        e.led     = ref_led;
        e.err     = ref_err;
        mis = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (nb == 2 && (off % 2) == 1) || (nb == 4 && off != 0);
        if (mis) ref_err = 1'b1;
`endif
        if (!mis && is_ram) begin
            if (load) begin
                v = 64'd0;
                for (int i = 0; i < nb; i++)
                    if (off + i < 4) v |= 64'(ref_mem[idx][8*(off+i) +: 8]) << (8 * i);
                if (sm[3] && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
                e.rdata  = v[31:0];
                e.stalls = RD_LAT;
            end else begin
                for (int i = 0; i < nb; i++)
                    if (off + i < 4) ref_mem[idx][8*(off+i) +: 8] = w[8*i +: 8];
                e.wes    = 1;
                e.stalls = (nb == 4 && off == 0) ? 0 : RD_LAT;
            end
        end else if (!mis && is_led) begin
            if (store) ref_led = w[7:0];
            else e.rdata = {24'd0, ref_led};
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the request dropped.
    task automatic do_op(input logic [31:0] a, input logic [31:0] w, input logic rd,
                         input logic wr, input logic [3:0] sm);
        exp_t e;
        int   n;
        model(a, w, rd, wr, sm, e);
        exp_q.push_back(e);
        bus.addr_i      = a;
        bus.wdata_i     = w;
        bus.memread_i   = rd;
        bus.memwrite_i  = wr;
        bus.sign_mask_i = sm;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.stall_o && n < 20);
        if (bus.stall_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: stall_o still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk);
        #1;
        bus.memread_i  = 1'b0;
        bus.memwrite_i = 1'b0;
    endtask

    initial begin : monitor
        int   sc, wc;
        exp_t e;
        sc = 0;
        wc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sc = 0;
                wc = 0;
            end else if (bus.memread_i || bus.memwrite_i) begin
                if (ram_we) wc++;
                if (bus.stall_o) begin
                    sc++;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard: completion seen with 0 expected entries, required 1");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_load) check("rdata", bus.rdata_o, e.rdata);
                        check("stall_cycles", 32'(sc), 32'(e.stalls));
                        check("we_pulses", 32'(wc), 32'(e.wes));
                        check("led", {24'd0, led}, {24'd0, e.led});
                        check("err", {31'd0, err}, {31'd0, e.err});
                    end
                    sc = 0;
                    wc = 0;
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] a, saved;
        int          r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        bus.addr_i      = 32'd0;
        bus.wdata_i     = 32'd0;
        bus.memread_i   = 1'b0;
        bus.memwrite_i  = 1'b0;
        bus.sign_mask_i = 4'd0;
        repeat (3) @(negedge clk);
        check("reset stall_o", {31'd0, bus.stall_o}, 32'd0);
        check("reset ram_we_o", {31'd0, ram_we}, 32'd0);
        check("reset led_o", {24'd0, led}, 32'd0);
        check("reset rdata_o", bus.rdata_o, 32'd0);
        check("reset err_o", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Directed sequence
        do_op(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0111);
        do_op(32'h13, 32'd0, 1'b1, 1'b0, 4'b1001);
        do_op(32'h12, 32'h0000_1234, 1'b0, 1'b1, 4'b0011);
        @(posedge clk);
        #1;
        check("rmw word", tb_ram[4], 32'h1234BEEF);
        do_op(32'h10, 32'd0, 1'b1, 1'b0, 4'b0011);
        do_op(32'h10, 32'd0, 1'b1, 1'b0, 4'b1011);
        do_op(32'h10, 32'd0, 1'b1, 1'b1, 4'b0111);
        do_op(32'h10, 32'd0, 1'b1, 1'b0, 4'b0111);
        do_op(32'h2000, 32'h0000_00A5, 1'b0, 1'b1, 4'b0111);
        check("led after store", {24'd0, led}, 32'h0000_00A5);
        do_op(32'h2000, 32'd0, 1'b1, 1'b0, 4'b0111);
        do_op(32'h9000, 32'd0, 1'b1, 1'b0, 4'b0111);
        do_op(32'h9000, 32'h1111_2222, 1'b0, 1'b1, 4'b0111);

`ifdef DMEM_MISALIGN_ERR_EN
        do_op(32'h11, 32'd0, 1'b1, 1'b0, 4'b0111);
        do_op(32'h10, 32'd0, 1'b1, 1'b0, 4'b0111);
        check("err sticky", {31'd0, err}, 32'd1);
`endif

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       a = 32'h2000 + $urandom_range(0, 3);
            else if (r == 2) a = 32'h9000 + $urandom_range(0, 1023);
            else             a = $urandom_range(0, 63);
            r = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0:       do_op(a, $urandom, r != 1, r != 0, {1'($urandom), 3'b001});
                1:       do_op(a, $urandom, r != 1, r != 0, {1'($urandom), 3'b011});
                default: do_op(a, $urandom, r != 1, r != 0, {1'($urandom), 3'b111});
            endcase
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset during the WAIT of a sub-word store
        do_op(32'h2000, 32'h0000_005A, 1'b0, 1'b1, 4'b0111);
        saved           = ref_mem[16];
        bus.addr_i      = 32'h40;
        bus.wdata_i     = 32'h0000_BEEF;
        bus.memwrite_i  = 1'b1;
        bus.sign_mask_i = 4'b0011;
        @(negedge clk);
        check("rmw stall before reset", {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.memwrite_i = 1'b0;
        #1;
        check("mid-reset stall_o", {31'd0, bus.stall_o}, 32'd0);
        check("mid-reset ram_we_o", {31'd0, ram_we}, 32'd0);
        check("mid-reset led_o", {24'd0, led}, 32'd0);
        ref_led = 8'd0;
        ref_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abandoned rmw word", tb_ram[16], saved);
        do_op(32'h40, 32'd0, 1'b1, 1'b0, 4'b0111);
        do_op(32'h2000, 32'h0000_00C3, 1'b0, 1'b1, 4'b0111);
        do_op(32'h2000, 32'd0, 1'b1, 1'b0, 4'b0111);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
